axi_sram_slave: RTL and testbench

//  AXI3 responder (slave) backed by on-chip SRAM; the memory-side counterpart of the CPU AXI master port.

---
 rtl/axi_sram_slave_pkg.sv | 22 ++
 rtl/axi_sram_slave_sram.sv | 27 ++
 rtl/axi_sram_slave.sv | 236 +++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI encodings and FSM state types for the SRAM-backed AXI3 responder.
package axi_sram_slave_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    // Worst response wins: decode error outranks slave error.
    function automatic logic [1:0] axi_resp(input logic decerr, input logic slverr);
        if (decerr)      return AXI_RESP_DECERR;
        else if (slverr) return AXI_RESP_SLVERR;
        else             return AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_sram_slave_sram.sv
// Word-wide SRAM: one synchronous read port, one byte-enabled write port, read-first.
module sram_1r1w #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb
);
    localparam int WORDS = 1 << AW;

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder backed by on-chip SRAM; independent read and write FSMs.
// Optional random back-pressure when AXI_SLAVE_BACKPRESSURE_EN is defined.
//
// state   | meaning
// R_IDLE  | arready high, waiting for a read address
// R_FETCH | SRAM read in flight for the current beat
// R_DATA  | rvalid high, beat held until rready
// W_IDLE  | awready high, write data held off
// W_DATA  | wready high, beats written as they arrive
// W_RESP  | bvalid high until bready
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int          MEM_BYTES = 65536,
    parameter int          ADDR_W    = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int              IDX_W     = $clog2(MEM_BYTES);
    localparam int              WA_W      = IDX_W - 2;
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    logic [2:0] ready_gate;
    logic       resp_gate;

`ifdef AXI_SLAVE_BACKPRESSURE_EN
    logic [15:0] lfsr;
    always_ff @(posedge aclk) begin
        if (areset) lfsr <= LFSR_SEED;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign ready_gate = lfsr[2:0];
    assign resp_gate  = lfsr[3];
    logic unused_lfsr;
    assign unused_lfsr = &{1'b0, lfsr};
`else
    assign ready_gate = 3'b111;
    assign resp_gate  = 1'b1;
`endif

    logic            mem_re, mem_we;
    logic [WA_W-1:0] mem_raddr, mem_waddr;
    logic [31:0]     mem_rdata;

    sram_1r1w #(.AW(WA_W)) u_sram (
        .clk   (aclk),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (wdata),
        .wstrb (wstrb)
    );

    r_state_e         r_state, r_state_nxt;
    logic [3:0]       r_id;
    logic [IDX_W-1:0] r_addr, r_addr_nxt;
    logic [7:0]       r_len, r_beat;
    logic [2:0]       r_size;
    logic [1:0]       r_burst;
    logic             r_decerr, r_slverr, r_final, ar_hs, r_hs;

    assign arready    = (r_state == R_IDLE) && ready_gate[0];
    assign rvalid     = (r_state == R_DATA);
    assign ar_hs      = arvalid && arready;
    assign r_hs       = rvalid && rready;
    assign r_final    = (r_beat == r_len);
    assign r_addr_nxt = (r_burst == AXI_BURST_FIXED) ? r_addr : r_addr + (IDX_W'(1) << r_size);

    assign rid   = r_id;
    assign rresp = rvalid ? axi_resp(r_decerr, r_slverr) : AXI_RESP_OKAY;
    assign rlast = rvalid && r_final;
    assign rdata = (rvalid && !r_decerr) ? mem_rdata : 32'h0;

    // The next beat is fetched during the current handshake so bursts sustain one beat per cycle.
    always_comb begin
        r_state_nxt = r_state;
        mem_re      = 1'b0;
        mem_raddr   = r_addr[IDX_W-1:2];
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_FETCH;
            R_FETCH: begin
                mem_re = 1'b1;
                if (resp_gate) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                if (rready) begin
                    if (r_final) begin
                        r_state_nxt = R_IDLE;
                    end else begin
                        mem_re    = 1'b1;
                        mem_raddr = r_addr_nxt[IDX_W-1:2];
                    end
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state  <= R_IDLE;
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_decerr <= 1'b0;
            r_slverr <= 1'b0;
        end else begin
            r_state <= r_state_nxt;
            if (ar_hs) begin
                r_id     <= arid;
                r_addr   <= araddr[IDX_W-1:0];
                r_len    <= arlen;
                r_beat   <= '0;
                r_size   <= arsize;
                r_burst  <= arburst;
                r_decerr <= {1'b0, araddr[ADDR_W-1:0]} >= MEM_LIMIT;
                r_slverr <= (arburst == AXI_BURST_WRAP) || (arsize > 3'd2);
            end else if (r_hs && !r_final) begin
                r_beat <= r_beat + 8'd1;
                r_addr <= r_addr_nxt;
            end
        end
    end

    w_state_e         w_state, w_state_nxt;
    logic [3:0]       w_id;
    logic [IDX_W-1:0] w_addr, w_addr_nxt;
    logic [7:0]       w_len, w_beat;
    logic [2:0]       w_size;
    logic [1:0]       w_burst;
    logic             w_decerr, w_slverr, w_done, w_final, aw_hs, w_hs;

    assign awready    = (w_state == W_IDLE) && ready_gate[1];
    assign wready     = (w_state == W_DATA) && !w_done && ready_gate[2];
    assign bvalid     = (w_state == W_RESP);
    assign aw_hs      = awvalid && awready;
    assign w_hs       = wvalid && wready;
    assign w_final    = w_hs && (wlast || (w_beat == w_len));
    assign w_addr_nxt = (w_burst == AXI_BURST_FIXED) ? w_addr : w_addr + (IDX_W'(1) << w_size);

    assign bid       = w_id;
    assign bresp     = bvalid ? axi_resp(w_decerr, w_slverr) : AXI_RESP_OKAY;
    assign mem_we    = w_hs && !w_decerr && !areset;
    assign mem_waddr = w_addr[IDX_W-1:2];

    // w_done parks a finished burst in W_DATA while the response is being held back.
    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE: if (aw_hs) w_state_nxt = W_DATA;
            W_DATA: if ((w_final || w_done) && resp_gate) w_state_nxt = W_RESP;
            W_RESP: if (bready) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state  <= W_IDLE;
            w_id     <= '0;
            w_addr   <= '0;
            w_len    <= '0;
            w_beat   <= '0;
            w_size   <= '0;
            w_burst  <= '0;
            w_decerr <= 1'b0;
            w_slverr <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            if (aw_hs) begin
                w_id     <= awid;
                w_addr   <= awaddr[IDX_W-1:0];
                w_len    <= awlen;
                w_beat   <= '0;
                w_size   <= awsize;
                w_burst  <= awburst;
                w_done   <= 1'b0;
                w_decerr <= {1'b0, awaddr[ADDR_W-1:0]} >= MEM_LIMIT;
                w_slverr <= (awburst == AXI_BURST_WRAP) || (awsize > 3'd2);
            end else if (w_hs) begin
                w_beat <= w_beat + 8'd1;
                w_addr <= w_addr_nxt;
                if ((wid != w_id) || ((w_beat == w_len) && !wlast)) w_slverr <= 1'b1;
                if (w_final && !resp_gate) w_done <= 1'b1;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, arlock, arcache, arprot, awlock, awcache, awprot, LFSR_SEED};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave (default build, no back-pressure).
module tb_axi_sram_slave;

    logic        aclk, areset;
    logic [3:0]  arid, rid, awid, wid, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    axi_sram_slave dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int passes = 0;
    logic [31:0] wd [8];
    logic [3:0]  ws [8];
    logic [31:0] ex [8];
    int bad_wid_beat = -1;
    logic drop_wlast = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [1:0] exp_resp, input string tag);
        int n;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(posedge aclk); #1; n++; end
        check({tag, "_aw_timeout"}, 32'(n < 20), 32'd1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wid    = (b == bad_wid_beat) ? (id ^ 4'd1) : id;
            wdata  = wd[b];
            wstrb  = ws[b];
            wlast  = (b == int'(len)) && !drop_wlast;
            wvalid = 1'b1;
            n = 0;
            while (!wready && n < 20) begin @(posedge aclk); #1; n++; end
            check({tag, "_w_timeout"}, 32'(n < 20), 32'd1);
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin @(posedge aclk); #1; n++; end
        check({tag, "_b_timeout"}, 32'(n < 20), 32'd1);
        check({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
        check({tag, "_bid"}, 32'(bid), 32'(id));
        @(posedge aclk); #1;
        bready = 1'b0;
        check({tag, "_b_done"}, 32'(bvalid), 32'd0);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [1:0] exp_resp, input int stall_beat,
                           input string tag);
        int n;
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(posedge aclk); #1; n++; end
        check({tag, "_ar_timeout"}, 32'(n < 20), 32'd1);
        @(posedge aclk); #1;
        arvalid = 1'b0; rready = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!rvalid && n < 20) begin @(posedge aclk); #1; n++; end
            check($sformatf("%s_lat%0d", tag, b), 32'(n), (b == 0) ? 32'd1 : 32'd0);
            if (b == stall_beat) begin
                rready = 1'b0;
                repeat (5) begin
                    @(posedge aclk); #1;
                    check({tag, "_stall_valid"}, 32'(rvalid), 32'd1);
                    check({tag, "_stall_data"}, rdata, ex[b]);
                    check({tag, "_stall_last"}, 32'(rlast), 32'(b == int'(len)));
                end
                rready = 1'b1;
            end
            check($sformatf("%s_data%0d", tag, b), rdata, ex[b]);
            check($sformatf("%s_resp%0d", tag, b), 32'(rresp), 32'(exp_resp));
            check($sformatf("%s_last%0d", tag, b), 32'(rlast), 32'(b == int'(len)));
            check($sformatf("%s_rid%0d", tag, b), 32'(rid), 32'(id));
            @(posedge aclk); #1;
        end
        rready = 1'b0;
        check({tag, "_r_done"}, 32'(rvalid), 32'd0);
    endtask

    initial begin
        areset = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arlock = '0;
        arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awlock = '0;
        awcache = '0; awprot = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rlast", 32'(rlast), 32'd0);
        check("rst_ids", 32'({rid, bid}), 32'd0);
        check("rst_resps", 32'({rresp, bresp}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        areset = 1'b0;
        @(posedge aclk); #1;

        // 1: single beat write then read back
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(4'd3, 32'h1000, 8'd0, 2'b01, 2'b00, "t1_wr");
        ex[0] = 32'hDEADBEEF;
        do_read(4'd3, 32'h1000, 8'd0, 2'b01, 2'b00, -1, "t1_rd");

        // 2: INCR burst with partial strobe over a prefilled region
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hFFFFFFFF; ws[i] = 4'hF; end
        do_write(4'd1, 32'h20, 8'd3, 2'b01, 2'b00, "t2_fill");
        wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
        ws[2] = 4'b0011;
        do_write(4'd2, 32'h20, 8'd3, 2'b01, 2'b00, "t2_wr");
        ex[0] = 32'd1; ex[1] = 32'd2; ex[2] = 32'hFFFF0003; ex[3] = 32'd4;
        do_read(4'd2, 32'h20, 8'd3, 2'b01, 2'b00, -1, "t2_rd");

        // WRAP burst: still performed as INCR, flagged SLVERR
        do_read(4'd4, 32'h20, 8'd1, 2'b10, 2'b10, -1, "wrap_rd");

        // 3: out-of-range accesses decode-error and leave the aliased word alone
        wd[0] = 32'hAAAA5555; ws[0] = 4'hF;
        do_write(4'd0, 32'h0, 8'd0, 2'b01, 2'b00, "t3_pre");
        ex[0] = 32'h0; ex[1] = 32'h0;
        do_read(4'd6, 32'h10000, 8'd1, 2'b01, 2'b11, -1, "t3_rd");
        wd[0] = 32'h12345678;
        do_write(4'd7, 32'h10000, 8'd0, 2'b01, 2'b11, "t3_wr");
        ex[0] = 32'hAAAA5555;
        do_read(4'd0, 32'h0, 8'd0, 2'b01, 2'b00, -1, "t3_chk");

        // wid mismatch and missing wlast both give SLVERR
        wd[0] = 32'h0; wd[1] = 32'h0; ws[0] = 4'hF; ws[1] = 4'hF;
        bad_wid_beat = 1;
        do_write(4'd8, 32'h200, 8'd1, 2'b01, 2'b10, "wid_err");
        bad_wid_beat = -1;
        drop_wlast = 1'b1;
        do_write(4'd9, 32'h204, 8'd0, 2'b01, 2'b10, "nolast_err");
        drop_wlast = 1'b0;

        // 4: rready stall mid-burst
        wd[0] = 32'h10; wd[1] = 32'h20; wd[2] = 32'h30; wd[3] = 32'h40;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        do_write(4'd5, 32'h80, 8'd3, 2'b01, 2'b00, "t4_wr");
        ex[0] = 32'h10; ex[1] = 32'h20; ex[2] = 32'h30; ex[3] = 32'h40;
        do_read(4'd5, 32'h80, 8'd3, 2'b01, 2'b00, 1, "t4_rd");

        // 5: reset during beat 2 of a 4-beat write
        awid = 4'd5; awaddr = 32'h100; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0;
        wid = 4'd5; wdata = 32'hCAFE0001; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
        @(posedge aclk); #1;
        wdata = 32'hCAFE0002; areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0; wvalid = 1'b0;
        check("t5_bvalid", 32'(bvalid), 32'd0);
        check("t5_wready", 32'(wready), 32'd0);
        check("t5_awready", 32'(awready), 32'd1);
        ex[0] = 32'hCAFE0001;
        do_read(4'd5, 32'h100, 8'd0, 2'b01, 2'b00, -1, "t5_rd");

        // 6: same-cycle read and write of one word is read-first
        wd[0] = 32'h11; ws[0] = 4'hF;
        do_write(4'd1, 32'h40, 8'd0, 2'b01, 2'b00, "t6_pre");
        awid = 4'd2; awaddr = 32'h40; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0;
        arid = 4'd2; araddr = 32'h40; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        @(posedge aclk); #1;
        arvalid = 1'b0;
        wid = 4'd2; wdata = 32'h55; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        @(posedge aclk); #1;
        wvalid = 1'b0; wlast = 1'b0;
        check("t6_rvalid", 32'(rvalid), 32'd1);
        check("t6_old_data", rdata, 32'h11);
        check("t6_bvalid", 32'(bvalid), 32'd1);
        check("t6_bresp", 32'(bresp), 32'd0);
        rready = 1'b1; bready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0; bready = 1'b0;
        check("t6_r_done", 32'(rvalid), 32'd0);
        check("t6_b_done", 32'(bvalid), 32'd0);
        ex[0] = 32'h55;
        do_read(4'd2, 32'h40, 8'd0, 2'b01, 2'b00, -1, "t6_new");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
